bcd_display_driver: RTL and testbench

BCD_DISPLAY_DRIVER -- requirements
Module: bcd_display_driver

---
 rtl/bcd_display_driver_pkg.sv | 44 ++++
 rtl/bcd_display_driver_seg7_decoder.sv | 32 +++
 rtl/bcd_display_driver.sv | 146 ++++++++++++++
 tb/tb_bcd_display_driver.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_display_driver_pkg.sv
// Shared definitions for the BCD display driver.
//   - state_t      : conversion FSM encoding (IDLE, SHIFT, DONE)
//   - SEG_*        : active-low 7-segment patterns {g,f,e,d,c,b,a}
//   - NUM_DIGITS   : number of decimal digits shown (5 covers 0..65535)
//   - dabble_adjust: the "add 3 to every nibble >= 5" step of double dabble
package bcd_display_driver_pkg;

    localparam int NUM_DIGITS = 5;
    localparam int VAL_W      = 16;
    localparam int BCD_W      = 4 * NUM_DIGITS;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Pre-shift correction: any nibble that would reach 10 or more after
    // doubling is bumped by 3 so the carry lands in the next decade.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_display_driver_seg7_decoder.sv
// Combinational BCD digit to 7-segment decoder, active-low segments.
//   Digit : 4-bit BCD digit (10..15 are treated as blank)
//   Blank : 1 forces all segments off
//   Seg   : {g,f,e,d,c,b,a}, 0 = segment lit
module seg7_decoder
    import bcd_display_driver_pkg::*;
(
    input  logic [3:0] Digit,
    input  logic       Blank,
    output logic [6:0] Seg
);

    always_comb begin
        Seg = SEG_BLANK;
        if (!Blank) begin
            case (Digit)
                4'd0:    Seg = SEG_0;
                4'd1:    Seg = SEG_1;
                4'd2:    Seg = SEG_2;
                4'd3:    Seg = SEG_3;
                4'd4:    Seg = SEG_4;
                4'd5:    Seg = SEG_5;
                4'd6:    Seg = SEG_6;
                4'd7:    Seg = SEG_7;
                4'd8:    Seg = SEG_8;
                4'd9:    Seg = SEG_9;
                default: Seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bcd_display_driver.sv
// Binary-to-BCD converter (double dabble) driving a 5-digit 7-segment display.
//   Clk       : system clock, rising edge
//   Rst       : asynchronous active-high reset
//   Start     : conversion request, sampled only in IDLE
//   Value     : 16-bit unsigned word to display
//   Busy      : high whenever the FSM is not IDLE
//   Done      : one-cycle pulse after the display registers update
//   Seg0..4   : active-low segments, Seg0 = units, Seg4 = ten-thousands
//   State     : current FSM state, for observation
//
// Handshake: Start acts as a valid with Busy as an inverted ready. A request
// is taken on the rising edge where the FSM is IDLE and Start=1; Start is
// ignored otherwise (no queuing). Value is captured only on that edge.
// Timing from accept edge k: shifts at k+1..k+16, display latch and Done
// at k+17, next accept possible at k+18.
module bcd_display_driver
    import bcd_display_driver_pkg::*;
#(
    parameter int BLANK_LEADING = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [VAL_W-1:0] Value,
    output logic             Busy,
    output logic             Done,
    output logic [6:0]       Seg0,
    output logic [6:0]       Seg1,
    output logic [6:0]       Seg2,
    output logic [6:0]       Seg3,
    output logic [6:0]       Seg4,
    output state_t           State
);

    state_t                 state, state_next;
    logic [VAL_W-1:0]       shift_q, shift_d;
    logic [BCD_W-1:0]       bcd_q, bcd_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BCD_W-1:0]       disp_q, disp_d;
    logic                   done_q, done_d;
    logic [BCD_W+VAL_W-1:0] shifted;

    logic [NUM_DIGITS-1:0]  blank;
    logic                   zero_run;
    logic [6:0]             seg_all [NUM_DIGITS];

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state   <= IDLE;
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_next;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        shift_d    = shift_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        disp_d     = disp_q;
        done_d     = 1'b0;
        shifted    = '0;

        case (state)
            IDLE: begin
                if (Start) begin
                    shift_d    = Value;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    state_next = SHIFT;
                end
            end

            SHIFT: begin
                // Adjust first, then shift the combined {bcd, binary} word
                // one place left; the binary MSB enters the BCD LSB.
                shifted = {dabble_adjust(bcd_q), shift_q} << 1;
                bcd_d   = shifted[BCD_W+VAL_W-1:VAL_W];
                shift_d = shifted[VAL_W-1:0];
                cnt_d   = cnt_q + 4'd1;
                // The 16th shift is the one that wraps the counter 15 -> 0.
                if (cnt_q == 4'd15) begin
                    state_next = DONE;
                end
            end

            DONE: begin
                disp_d     = bcd_q;
                done_d     = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign Busy  = (state != IDLE);
    assign Done  = done_q;
    assign State = state;

    // ------------------------------------------------------------------
    // Leading-zero blanking: a digit above the units is blank only when it
    // and every higher digit are zero. Digit 0 always shows.
    // ------------------------------------------------------------------
    always_comb begin
        blank    = '0;
        zero_run = (BLANK_LEADING != 0);
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (disp_q[4*i +: 4] == 4'd0);
            blank[i] = zero_run;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        seg7_decoder u_dec (
            .Digit (disp_q[4*g +: 4]),
            .Blank (blank[g]),
            .Seg   (seg_all[g])
        );
    end

    assign Seg0 = seg_all[0];
    assign Seg1 = seg_all[1];
    assign Seg2 = seg_all[2];
    assign Seg3 = seg_all[3];
    assign Seg4 = seg_all[4];

endmodule

// File: tb/tb_bcd_display_driver.sv
module tb_bcd_display_driver;
  import bcd_display_driver_pkg::*;

  // clock / reset
  logic Clk = 1'b0;
  logic Rst;
  logic Start;
  logic [15:0] Value;

  always #5 Clk = ~Clk;

  // DUT with leading-zero blanking
  logic busy_b, done_b;
  logic [6:0] s0_b, s1_b, s2_b, s3_b, s4_b;
  state_t st_b;
  logic [34:0] segs_b;
  assign segs_b = {s4_b, s3_b, s2_b, s1_b, s0_b};

  // DUT showing all digits
  logic busy_n, done_n;
  logic [6:0] s0_n, s1_n, s2_n, s3_n, s4_n;
  state_t st_n;
  logic [34:0] segs_n;
  assign segs_n = {s4_n, s3_n, s2_n, s1_n, s0_n};

  bcd_display_driver #(.BLANK_LEADING(1)) dut_b (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Value(Value),
    .Busy(busy_b), .Done(done_b),
    .Seg0(s0_b), .Seg1(s1_b), .Seg2(s2_b), .Seg3(s3_b), .Seg4(s4_b),
    .State(st_b)
  );

  bcd_display_driver #(.BLANK_LEADING(0)) dut_n (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Value(Value),
    .Busy(busy_n), .Done(done_n),
    .Seg0(s0_n), .Seg1(s1_n), .Seg2(s2_n), .Seg3(s3_n), .Seg4(s4_n),
    .State(st_n)
  );

  // scoreboard counters
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // vector table: value, expected {Seg4..Seg0} blanking / non-blanking
  typedef struct {
    logic [15:0] value;
    logic [34:0] exp_b;
    logic [34:0] exp_n;
  } vec_t;

  vec_t vecs [8];

  // One conversion accepted at edge k; checks latency, Busy, frozen segments,
  // final display and the one-cycle Done pulse. Ends #1 after edge k+18.
  task automatic run_conv(input logic [15:0] v, input logic [34:0] eb,
                          input logic [34:0] en, input string tag);
    logic [34:0] prev_b;
    int n;
    bit moved;
    bit busy_gap;
    @(negedge Clk);
    Start = 1'b1;
    Value = v;
    @(posedge Clk);               // edge k
    #1;
    Start = 1'b0;
    Value = ~v;                   // must not affect the running conversion
    chk({tag, " busy_at_k"}, 64'(busy_b), 64'd1);
    prev_b = segs_b;
    moved = 0;
    busy_gap = 0;
    n = 0;
    while (done_b !== 1'b1 && n < 40) begin
      @(posedge Clk);
      #1;
      n++;
      if (done_b !== 1'b1) begin
        if (segs_b !== prev_b) moved = 1;
        if (busy_b !== 1'b1) busy_gap = 1;
      end
    end
    chk({tag, " done_latency"}, 64'(n), 64'd17);
    chk({tag, " segs_frozen"}, 64'(moved), 64'd0);
    chk({tag, " busy_held"}, 64'(busy_gap), 64'd0);
    chk({tag, " segs_blank"}, 64'(segs_b), 64'(eb));
    chk({tag, " segs_noblank"}, 64'(segs_n), 64'(en));
    chk({tag, " busy_at_done"}, 64'(busy_b), 64'd0);
    @(posedge Clk);               // edge k+18
    #1;
    chk({tag, " done_width"}, 64'(done_b), 64'd0);
  endtask

  initial begin
    int n;
    bit saw_done;

    vecs[0] = '{16'd1234,  {7'h7F, 7'h79, 7'h24, 7'h30, 7'h19}, {7'h40, 7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[1] = '{16'd65535, {7'h02, 7'h12, 7'h12, 7'h30, 7'h12}, {7'h02, 7'h12, 7'h12, 7'h30, 7'h12}};
    vecs[2] = '{16'd46368, {7'h19, 7'h02, 7'h30, 7'h02, 7'h00}, {7'h19, 7'h02, 7'h30, 7'h02, 7'h00}};
    vecs[3] = '{16'd0,     {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[4] = '{16'd7,     {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78}, {7'h40, 7'h40, 7'h40, 7'h40, 7'h78}};
    vecs[5] = '{16'd10000, {7'h79, 7'h40, 7'h40, 7'h40, 7'h40}, {7'h79, 7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[6] = '{16'd905,   {7'h7F, 7'h7F, 7'h10, 7'h40, 7'h12}, {7'h40, 7'h40, 7'h10, 7'h40, 7'h12}};
    vecs[7] = '{16'd42,    {7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24}, {7'h40, 7'h40, 7'h40, 7'h19, 7'h24}};

    // reset then idle
    Rst = 1'b1;
    Start = 1'b0;
    Value = 16'd0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset busy", 64'(busy_b), 64'd0);
    chk("reset done", 64'(done_b), 64'd0);
    chk("reset state", 64'(st_b), 64'(IDLE));
    chk("reset segs_blank", 64'(segs_b), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}));
    chk("reset segs_noblank", 64'(segs_n), 64'({7'h40, 7'h40, 7'h40, 7'h40, 7'h40}));

    // table-driven conversions
    for (int i = 0; i < 8; i++) begin
      run_conv(vecs[i].value, vecs[i].exp_b, vecs[i].exp_n, $sformatf("vec%0d", i));
    end

    // Start held high, Value changed during SHIFT
    @(negedge Clk);
    Start = 1'b1;
    Value = 16'd1234;
    @(posedge Clk);               // edge k
    #1;
    Value = 16'd9999;
    n = 0;
    while (done_b !== 1'b1 && n < 40) begin
      @(posedge Clk);
      #1;
      n++;
    end
    chk("held latency", 64'(n), 64'd17);
    chk("held segs_orig", 64'(segs_b), 64'(vecs[0].exp_b));
    chk("held busy_at_done", 64'(busy_b), 64'd0);
    @(posedge Clk);               // edge k+18: re-accept
    #1;
    chk("held done_width", 64'(done_b), 64'd0);
    chk("held reaccept_busy", 64'(busy_b), 64'd1);
    chk("held reaccept_state", 64'(st_b), 64'(SHIFT));
    Start = 1'b0;
    n = 0;
    while (done_b !== 1'b1 && n < 40) begin
      @(posedge Clk);
      #1;
      n++;
    end
    chk("held second_latency", 64'(n), 64'd17);
    chk("held second_segs", 64'(segs_b), 64'({7'h7F, 7'h10, 7'h10, 7'h10, 7'h10}));
    @(posedge Clk);
    #1;

    // Rst at edge k+8 of a 9999 conversion
    @(negedge Clk);
    Start = 1'b1;
    Value = 16'd9999;
    @(posedge Clk);               // edge k
    #1;
    Start = 1'b0;
    repeat (7) @(posedge Clk);    // edge k+7
    @(negedge Clk);
    Rst = 1'b1;
    #1;
    chk("abort async_busy", 64'(busy_b), 64'd0);
    chk("abort async_segs", 64'(segs_b), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}));
    @(posedge Clk);               // edge k+8 under reset
    #1;
    chk("abort done", 64'(done_b), 64'd0);
    chk("abort state", 64'(st_b), 64'(IDLE));
    @(negedge Clk);
    Rst = 1'b0;
    saw_done = 0;
    repeat (20) begin
      @(posedge Clk);
      #1;
      if (done_b === 1'b1 || busy_b === 1'b1) saw_done = 1;
    end
    chk("abort no_done", 64'(saw_done), 64'd0);
    chk("abort display_zero", 64'(segs_b), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}));
    run_conv(16'd42, vecs[7].exp_b, vecs[7].exp_n, "after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
